instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly downstream of the instruction register file (IR memory).
- Owns the program counter and drives the IR memory read address.
- Captures returned instruction words into a 2-entry buffer and presents them to the decoder over a valid/ready handshake.
- Supports branch redirect and halts while the IR memory is in load mode.

Parameters:
- ADDR_W, 8, IR memory address width; PC width; memory depth 2**ADDR_W.
- DATA_W, 16, instruction word width.
- RESET_PC, 0, fetch start address after reset and after load mode exits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- load_mode  in  1  1 = IR memory being written; fetch suspended
- imem_addr  out  ADDR_W  read address to IR memory
- imem_rd_en  out  1  a fetch is issued this cycle
- imem_rdata  in  DATA_W  IR memory read data, valid exactly 1 cycle after issue
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  ADDR_W  new fetch address
- instr_valid  out  1  instruction available to decoder
- instr_data  out  DATA_W  instruction word
- instr_pc  out  ADDR_W  address of instr_data
- instr_ready  in  1  decoder accepts the instruction

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=LOAD, pc=RESET_PC, buffer empty, no fetch in flight.
  - imem_addr=RESET_PC, imem_rd_en=0.
  - instr_valid=0, instr_data=0, instr_pc=0.
- FSM states and transitions:
  - LOAD: no issue; buffer held empty; pc=RESET_PC. Go to RUN when load_mode=0.
  - RUN: normal fetch. Go to LOAD when load_mode=1; this flushes buffer and in-flight fetch and forces pc=RESET_PC.
- Issue rule in RUN:
  - imem_rd_en=1 iff (buffer_count + inflight) < 2 and redirect_valid=0.
  - imem_addr=pc (combinational from the pc register).
  - On issue, pc <= pc+1 modulo 2**ADDR_W; 2**ADDR_W-1 wraps to 0.
- Return path:
  - An issue in cycle N sets inflight=1 and records the issued pc.
  - At cycle N+1, imem_rdata plus the recorded pc are written into the buffer unless squashed.
  - Latency: address issue to instr_valid = 1 cycle when the buffer is empty.
- Buffer and output:
  - 2-entry FIFO; instr_valid = not empty; instr_data/instr_pc show the head entry.
  - Transfer when instr_valid and instr_ready; head is popped.
  - Push and pop in the same cycle are allowed; the credit check above guarantees no overflow.
  - instr_data/instr_pc hold their last value while instr_valid=0; they are 0 after reset.
- Redirect (redirect_valid=1 in cycle R):
  - No issue in R; pc <= redirect_pc.
  - Buffer cleared at end of R; any fetch in flight from R-1 is squashed (never enters the buffer).
  - A handshake completing in R still counts as transferred.
  - First issue at redirect_pc in R+1; instr_valid in R+2.
  - Back-to-back redirects: the last one wins.
- Simultaneous events:
  - load_mode=1 overrides redirect_valid.
  - Reset overrides everything.
  - Reset or load_mode mid-operation discards all buffered and in-flight words.
- Throughput: with instr_ready held 1, one instruction per cycle sustained.
- Backpressure: with instr_ready=0, issue stops after buffer_count+inflight reaches 2; no word is lost or duplicated.

Decomposition:
- Shared package (processor-wide; the IR memory already uses these widths):
  - ADDR_W/DATA_W defaults, RESET_PC.
  - Fetch FSM state enum {LOAD, RUN}.
  - Fetch-entry struct {pc, data}.
- Sub-module fetch_skid_fifo:
  - 2-entry FIFO of fetch entries with push, pop, flush, count, head.
- Top level holds the FSM, pc, inflight/squash tracking and credit logic.

Test Plan:
- Reset, then load_mode=0 with instr_ready=1; memory holds word=addr+0x100 -> issue addr 0 in cycle 1, instr_valid from cycle 2; sequence pc 0,1,2,... data 0x0100,0x0101,... one per cycle.
- instr_ready=0 after first word -> exactly two issues outstanding/buffered, imem_rd_en=0 thereafter. Release ready -> pcs 0,1,2 delivered in order, no gaps or duplicates.
- Redirect to 0x40 while pc=0x05 with a fetch in flight -> squashed word never appears. Next instr_pc=0x40 two cycles after redirect; a handshake completing in the redirect cycle is accepted.
- Redirect to 0xFE, run 4 instructions -> instr_pc sequence 0xFE,0xFF,0x00,0x01 (wrap).
- load_mode=1 mid-stream with full buffer -> instr_valid=0 next cycle, imem_rd_en=0. Drop load_mode -> fetch restarts at RESET_PC=0.
- rst_n=0 for one cycle during redirect plus backpressure -> all outputs at reset values next cycle; restart from pc 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path definitions: default widths, start address, fetch FSM
// state encodings and the fetch-entry layout used between IR memory and decoder.
package instr_fetch_unit_pkg;

    localparam int          IFU_ADDR_W   = 8;
    localparam int          IFU_DATA_W   = 16;
    localparam int unsigned IFU_RESET_PC = 0;

    typedef logic [0:0] fetch_state_t;

    localparam fetch_state_t ST_LOAD = 1'b0;
    localparam fetch_state_t ST_RUN  = 1'b1;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_skid_fifo.sv
// Two-entry FIFO holding fetched {pc, data} words until the decoder takes them.
// Flush wins over push/pop; the caller guarantees it never pushes when full
// without popping in the same cycle.
module instr_fetch_unit_skid_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int WIDTH = IFU_ADDR_W + IFU_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to the IR memory,
// buffers returned words and hands them to the decoder over valid/ready.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_LOAD | IR memory being written; no issue, buffer empty, pc=RESET_PC
//   ST_RUN  | normal fetch; credit-limited issue, redirect, buffered output
//
// A returning word is shown to the decoder in the same cycle it arrives
// (bypassing the FIFO when it is empty), so issue-to-valid is one cycle.
// Outstanding credit (buffered + in flight) is capped at two.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = IFU_ADDR_W,
    parameter int          DATA_W   = IFU_DATA_W,
    parameter int unsigned RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mode,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
    localparam int                ENTRY_W = ADDR_W + DATA_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    logic               run;
    logic [1:0]         outstanding;
    logic               issue;
    logic               ret_live;
    logic               fifo_empty;
    logic               out_valid;
    logic [ENTRY_W-1:0] out_entry;
    logic               xfer;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic [1:0]         fifo_count;
    logic [ENTRY_W-1:0] fifo_head;

    // Credit, issue, squash and output-path decisions for this cycle
    always_comb begin
        run         = (state_q == ST_RUN);
        outstanding = fifo_count + {1'b0, inflight_q};
        issue       = run && !load_mode && !redirect_valid && (outstanding < 2'd2);
        // A word returning during a redirect or load request is squashed
        ret_live    = run && inflight_q && !load_mode && !redirect_valid;
        fifo_empty  = (fifo_count == 2'd0);
        out_valid   = run && (!fifo_empty || ret_live);
        out_entry   = fifo_empty ? {inflight_pc_q, imem_rdata} : fifo_head;
        xfer        = out_valid && instr_ready;
        fifo_pop    = xfer && !fifo_empty;
        // The returning word skips the FIFO when it is taken straight away
        fifo_push   = ret_live && !(xfer && fifo_empty);
        fifo_flush  = !run || load_mode || redirect_valid;
    end

    // Fetch FSM and program counter
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == ST_LOAD) begin
            pc_d = RST_PC;
            if (!load_mode) begin
                state_d = ST_RUN;
            end
        end else begin
            if (load_mode) begin
                state_d = ST_LOAD;
                pc_d    = RST_PC;
            end else if (redirect_valid) begin
                pc_d = redirect_pc;
            end else if (issue) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    // In-flight tracking and last-shown output value
    always_comb begin
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        hold_pc_d     = hold_pc_q;
        hold_data_d   = hold_data_q;
        if (out_valid) begin
            hold_pc_d   = out_entry[ENTRY_W-1:DATA_W];
            hold_data_d = out_entry[DATA_W-1:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            pc_q          <= RST_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            hold_pc_q     <= '0;
            hold_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_data_q   <= hold_data_d;
        end
    end

    instr_fetch_unit_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i ({inflight_pc_q, imem_rdata}),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign imem_addr   = pc_q;
    assign imem_rd_en  = issue;
    assign instr_valid = out_valid;
    assign instr_pc    = out_valid ? out_entry[ENTRY_W-1:DATA_W] : hold_pc_q;
    assign instr_data  = out_valid ? out_entry[DATA_W-1:0] : hold_data_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: IR memory model returns addr+0x100
// one cycle after issue; delivered words are checked against an in-order
// scoreboard of expected pcs, plus cycle-exact checks at key points.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_mode;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata = 16'h0;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;
    logic        instr_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // IR memory: word = address + 0x100, valid the cycle after issue
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= 16'h0100 + {8'h00, imem_addr};
    end

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_mode      (load_mode),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = 16'h0100 + {8'h00, pc};
        exp_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra observed pc=%0h expected no transfer", instr_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", {24'h0, instr_pc}, {24'h0, e.pc});
                chk("sb_data", {16'h0, instr_data}, {16'h0, e.data});
            end
        end
    endtask

    task automatic settle();
        #1;
        sb_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        load_mode      = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        adv();
        adv();
        settle();
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_data", {16'h0, instr_data}, 32'h0);
        chk("rst_pc", {24'h0, instr_pc}, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h0);
        chk("rst_rd_en", {31'h0, imem_rd_en}, 32'h0);
        rst_n = 1'b1;
        adv();

        // L0: leave load mode, stream with ready high
        load_mode   = 1'b0;
        instr_ready = 1'b1;
        push_exp(8'h00); push_exp(8'h01); push_exp(8'h02); push_exp(8'h03);
        settle();
        chk("load_no_issue", {31'h0, imem_rd_en}, 32'h0);
        adv();
        // L1: first issue at 0
        settle();
        chk("first_issue", {31'h0, imem_rd_en}, 32'h1);
        chk("first_addr", {24'h0, imem_addr}, 32'h0);
        chk("first_not_valid", {31'h0, instr_valid}, 32'h0);
        adv();
        // L2: first word visible, accepted
        settle();
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        chk("second_addr", {24'h0, imem_addr}, 32'h1);
        adv();
        // L3: backpressure starts
        instr_ready = 1'b0;
        settle();
        chk("bp_issue_2", {31'h0, imem_rd_en}, 32'h1);
        chk("bp_addr_2", {24'h0, imem_addr}, 32'h2);
        adv();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_no_issue", {31'h0, imem_rd_en}, 32'h0);
            chk("bp_head_pc", {24'h0, instr_pc}, 32'h1);
            adv();
        end
        // L7: release; credit still exhausted this cycle
        instr_ready = 1'b1;
        settle();
        chk("release_no_issue", {31'h0, imem_rd_en}, 32'h0);
        adv();
        // L8
        settle();
        chk("resume_addr", {24'h0, imem_addr}, 32'h3);
        adv();
        // L9: hold one word so a buffered word and a fetch in flight coexist
        instr_ready = 1'b0;
        settle();
        adv();
        // L10: redirect to 0x40 while pc=5; buffered pc 3 is accepted
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        push_exp(8'h40);
        settle();
        chk("redir_pc_reg", {24'h0, imem_addr}, 32'h5);
        chk("redir_valid", {31'h0, instr_valid}, 32'h1);
        chk("redir_no_issue", {31'h0, imem_rd_en}, 32'h0);
        adv();
        // L11: outputs hold the last shown word
        redirect_valid = 1'b0;
        settle();
        chk("redir_gap", {31'h0, instr_valid}, 32'h0);
        chk("hold_pc", {24'h0, instr_pc}, 32'h3);
        chk("hold_data", {16'h0, instr_data}, 32'h0103);
        chk("redir_issue_addr", {24'h0, imem_addr}, 32'h40);
        adv();
        // L12
        settle();
        chk("redir_latency", {24'h0, instr_pc}, 32'h40);
        adv();
        // L13, L14: back-to-back redirects, last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        settle();
        chk("squash_visible", {31'h0, instr_valid}, 32'h0);
        adv();
        redirect_pc = 8'hFE;
        push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00);
        push_exp(8'h01); push_exp(8'h02); push_exp(8'h03);
        settle();
        chk("b2b_no_issue", {31'h0, imem_rd_en}, 32'h0);
        adv();
        // L15
        redirect_valid = 1'b0;
        settle();
        chk("b2b_addr", {24'h0, imem_addr}, 32'hFE);
        adv();
        // L16..L21: one per cycle across the wrap
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("tput_valid", {31'h0, instr_valid}, 32'h1);
            adv();
        end
        // L22, L23: fill the buffer
        instr_ready = 1'b0;
        settle();
        adv();
        settle();
        chk("fill_no_issue", {31'h0, imem_rd_en}, 32'h0);
        adv();
        // L24: load mode with full buffer
        load_mode = 1'b1;
        settle();
        chk("load_req_valid", {31'h0, instr_valid}, 32'h1);
        chk("load_req_no_issue", {31'h0, imem_rd_en}, 32'h0);
        adv();
        // L25
        settle();
        chk("load_flush_valid", {31'h0, instr_valid}, 32'h0);
        chk("load_rd_en", {31'h0, imem_rd_en}, 32'h0);
        chk("load_addr", {24'h0, imem_addr}, 32'h0);
        chk("load_hold_pc", {24'h0, instr_pc}, 32'h4);
        adv();
        // L26: exit load mode, restart at RESET_PC
        load_mode   = 1'b0;
        instr_ready = 1'b1;
        push_exp(8'h00);
        settle();
        adv();
        settle();
        chk("restart_addr", {24'h0, imem_addr}, 32'h0);
        chk("restart_issue", {31'h0, imem_rd_en}, 32'h1);
        adv();
        settle();
        chk("restart_valid", {31'h0, instr_valid}, 32'h1);
        adv();
        // L29, L30: backpressure, then reset during a redirect
        instr_ready = 1'b0;
        settle();
        adv();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h90;
        rst_n          = 1'b0;
        settle();
        adv();
        // L31: reset values
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
        settle();
        chk("rst2_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst2_data", {16'h0, instr_data}, 32'h0);
        chk("rst2_pc", {24'h0, instr_pc}, 32'h0);
        chk("rst2_rd_en", {31'h0, imem_rd_en}, 32'h0);
        chk("rst2_addr", {24'h0, imem_addr}, 32'h0);
        adv();
        settle();
        chk("rst2_issue", {31'h0, imem_rd_en}, 32'h1);
        adv();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst2_stream", {31'h0, instr_valid}, 32'h1);
            adv();
        end
        instr_ready = 1'b0;
        settle();
        chk("sb_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
